// File: rtl/i2c_reg_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_reg_sequencer_if
//  Purpose  : Bundles the host request/response signals and the i2c_master
//             strobe/status signals of i2c_reg_sequencer.
//  Modports : slave  - the sequencer (takes host requests, drives master
//                      strobes, receives master status/data)
//             master - the environment (host + i2c_master side)
//  Signals  : i_req, i_rd, i_dev_addr[6:0], i_reg_addr[7:0], i_wr_data[7:0]
//             o_busy, o_done, o_err[1:0], o_rd_data[7:0]
//             o_addr_cmd_data[7:0], o_start, o_rw_data, o_stop
//             i_status[3:0] = {nack_addr, nack_data, tx_in_progress,
//             data_ready}, i_data[7:0]
//  Revision : 1.0 - initial release
// ============================================================================
interface i2c_reg_sequencer_if;
    // host request side
    logic       i_req;
    logic       i_rd;
    logic [6:0] i_dev_addr;
    logic [7:0] i_reg_addr;
    logic [7:0] i_wr_data;
    // host response side
    logic       o_busy;
    logic       o_done;
    logic [1:0] o_err;
    logic [7:0] o_rd_data;
    // i2c_master command side
    logic [7:0] o_addr_cmd_data;
    logic       o_start;
    logic       o_rw_data;
    logic       o_stop;
    // i2c_master status side (asynchronous to m_clk)
    logic [3:0] i_status;
    logic [7:0] i_data;

    modport slave (
        input  i_req, i_rd, i_dev_addr, i_reg_addr, i_wr_data,
        input  i_status, i_data,
        output o_busy, o_done, o_err, o_rd_data,
        output o_addr_cmd_data, o_start, o_rw_data, o_stop
    );

    modport master (
        output i_req, i_rd, i_dev_addr, i_reg_addr, i_wr_data,
        output i_status, i_data,
        input  o_busy, o_done, o_err, o_rd_data,
        input  o_addr_cmd_data, o_start, o_rw_data, o_stop
    );
endinterface
`default_nettype wire

// File: rtl/i2c_reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_reg_sequencer
//  Purpose  : Turns one host register-access request into the complete
//             i2c_master strobe sequence.
//               write: START {dev,0}, reg byte, data byte, STOP
//               read : START {dev,0}, reg byte, START {dev,1}, STOP
//             Synchronises the master status bus, returns the read byte and
//             a 2-bit result code (00 ok, 01 addr NACK, 10 data NACK,
//             11 timeout), and aborts a step that exceeds TIMEOUT cycles.
//  Ports    : m_clk  - system clock (also clocks i2c_master)
//             reset  - synchronous, active-high
//             bus    - i2c_reg_sequencer_if.slave (host + master signals)
//  Params   : TIMEOUT - max m_clk cycles per step (issue + completion)
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_reg_sequencer #(
    parameter int TIMEOUT = 65535
) (
    input  wire logic          m_clk,
    input  wire logic          reset,
    i2c_reg_sequencer_if.slave bus
);

    localparam int                 c_cnt_w     = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_tmo_limit = c_cnt_w'(TIMEOUT);

    localparam logic [1:0] c_step_addr = 2'd0;
    localparam logic [1:0] c_step_reg  = 2'd1;
    localparam logic [1:0] c_step_two  = 2'd2;  // write data or repeated START
    localparam logic [1:0] c_step_stop = 2'd3;

    localparam logic [1:0] c_err_ok    = 2'b00;
    localparam logic [1:0] c_err_naddr = 2'b01;
    localparam logic [1:0] c_err_ndata = 2'b10;
    localparam logic [1:0] c_err_tmo   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Status synchroniser
    // ------------------------------------------------------------------
    logic [3:0] r_status_s1;
    logic [3:0] r_status_s2;

    always_ff @(posedge m_clk) begin
        if (reset) begin
            r_status_s1 <= 4'h0;
            r_status_s2 <= 4'h0;
        end else begin
            r_status_s1 <= bus.i_status;
            r_status_s2 <= r_status_s1;
        end
    end

    logic w_st_nack_addr;
    logic w_st_nack_data;
    logic w_st_tip;
    logic w_st_data_ready;

    assign w_st_nack_addr  = r_status_s2[3];
    assign w_st_nack_data  = r_status_s2[2];
    assign w_st_tip        = r_status_s2[1];
    assign w_st_data_ready = r_status_s2[0];

    // ------------------------------------------------------------------
    // Strobe/byte pattern for a given step: {start, rw_data, stop, byte}.
    // Exactly one strobe bit is set for every step.
    // ------------------------------------------------------------------
    function automatic logic [10:0] step_drive(
        input logic [1:0] s,
        input logic       rd,
        input logic [6:0] dev,
        input logic [7:0] rg,
        input logic [7:0] wd
    );
        case (s)
            c_step_addr: return {3'b100, dev, 1'b0};
            c_step_reg:  return {3'b010, rg};
            c_step_two:  return rd ? {3'b100, dev, 1'b1} : {3'b010, wd};
            default:     return {3'b001, 8'h00};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [1:0]         r_step;
    logic [c_cnt_w-1:0] r_tmo_cnt;

    logic               r_rd;
    logic [6:0]         r_dev;
    logic [7:0]         r_reg;
    logic [7:0]         r_wdata;

    logic               r_busy;
    logic               r_done;
    logic [1:0]         r_err;
    logic [7:0]         r_rd_data;
    logic [7:0]         r_acd;
    logic               r_start;
    logic               r_rw_data;
    logic               r_stop;

    logic [1:0]         w_step_inc;
    assign w_step_inc = r_step + 2'd1;

    always_ff @(posedge m_clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_step    <= 2'd0;
            r_tmo_cnt <= '0;
            r_rd      <= 1'b0;
            r_dev     <= 7'h00;
            r_reg     <= 8'h00;
            r_wdata   <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= c_err_ok;
            r_rd_data <= 8'h00;
            r_acd     <= 8'h00;
            r_start   <= 1'b0;
            r_rw_data <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.i_req) begin
                        r_rd      <= bus.i_rd;
                        r_dev     <= bus.i_dev_addr;
                        r_reg     <= bus.i_reg_addr;
                        r_wdata   <= bus.i_wr_data;
                        r_err     <= c_err_ok;
                        r_step    <= c_step_addr;
                        r_tmo_cnt <= '0;
                        r_busy    <= 1'b1;
                        {r_start, r_rw_data, r_stop, r_acd} <=
                            step_drive(c_step_addr, bus.i_rd, bus.i_dev_addr,
                                       bus.i_reg_addr, bus.i_wr_data);
                        r_state   <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (r_tmo_cnt == c_tmo_limit) begin
                        // The master is left as-is; the system has to reset it.
                        {r_start, r_rw_data, r_stop, r_acd} <= 11'h000;
                        r_err   <= c_err_tmo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_st_tip) begin
                        // Master has taken the command; release the strobe.
                        r_start   <= 1'b0;
                        r_rw_data <= 1'b0;
                        r_stop    <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (r_tmo_cnt == c_tmo_limit) begin
                        r_acd   <= 8'h00;
                        r_err   <= c_err_tmo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (!w_st_tip) begin
                        if (w_st_nack_addr) begin
                            // Master already returned to idle: no STOP needed.
                            r_acd   <= 8'h00;
                            r_err   <= c_err_naddr;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_st_nack_data) begin
                            r_acd   <= 8'h00;
                            r_err   <= c_err_ndata;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (r_step == c_step_stop) begin
                            r_acd   <= 8'h00;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (r_rd && (r_step == c_step_two)) begin
                            // i_data is stable while data_ready is high, so it
                            // is sampled directly without synchronisation.
                            if (w_st_data_ready) begin
                                r_rd_data <= bus.i_data;
                                r_step    <= c_step_stop;
                                r_tmo_cnt <= '0;
                                {r_start, r_rw_data, r_stop, r_acd} <=
                                    step_drive(c_step_stop, r_rd, r_dev,
                                               r_reg, r_wdata);
                                r_state   <= S_ISSUE;
                            end
                        end else begin
                            r_step    <= w_step_inc;
                            r_tmo_cnt <= '0;
                            {r_start, r_rw_data, r_stop, r_acd} <=
                                step_drive(w_step_inc, r_rd, r_dev,
                                           r_reg, r_wdata);
                            r_state   <= S_ISSUE;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy          = r_busy;
    assign bus.o_done          = r_done;
    assign bus.o_err           = r_err;
    assign bus.o_rd_data       = r_rd_data;
    assign bus.o_addr_cmd_data = r_acd;
    assign bus.o_start         = r_start;
    assign bus.o_rw_data       = r_rw_data;
    assign bus.o_stop          = r_stop;

endmodule
`default_nettype wire

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

Host-side transaction controller that sequences `i2c_master` through complete register-access transactions. A single host request (device address, register address, optional write byte) becomes the master's strobe sequence:
- Write: START, register byte, data byte, STOP.
- Read: START, register byte, repeated START with read bit, STOP.

The block runs on the system clock, synchronises the master's status bus, reports completion, the read byte and a 2-bit error code, and aborts on timeout.

## Interface
Parameters:
- `TIMEOUT`, 65535, max `m_clk` cycles allowed per step (issue + completion) before abort; counter width = clog2(`TIMEOUT`+1).

Ports:
- `m_clk` in 1: system clock (same clock that feeds `i2c_master.m_clk`).
- `reset` in 1: synchronous, active-high reset.
- `i_req` in 1: start a transaction; sampled only in `S_IDLE`.
- `i_rd` in 1: 1 = register read, 0 = register write; latched with `i_req`.
- `i_dev_addr` in 7: 7-bit slave address; latched with `i_req`.
- `i_reg_addr` in 8: register index; latched with `i_req`.
- `i_wr_data` in 8: write byte; latched with `i_req`.
- `o_busy` out 1: transaction in progress.
- `o_done` out 1: one-cycle completion pulse.
- `o_err` out 2: result code, valid with `o_done` and held until the next accepted request. 00 = ok, 01 = address NACK, 10 = data NACK, 11 = timeout.
- `o_rd_data` out 8: read byte, valid with `o_done` when `i_rd`=1 and `o_err`=00; held until the next read completes.
- `o_addr_cmd_data` out 8: to master `i_addr_cmd_data`.
- `o_start`, `o_rw_data`, `o_stop` out 1 each: master strobes.
- `i_status` in 4: master `o_status` = {nack_addr, nack_data, tx_in_progress, data_ready}; asynchronous to `m_clk`.
- `i_data` in 8: master `o_data`.

## Operation
- Status synchroniser:
  - `i_status` passes through a 2-flop synchroniser, giving `st_*`.
  - `i_data` is captured directly, only when `st_data_ready`=1 (data is stable while data_ready is high).
- Step list, held in a 2-bit step counter `step`:
  - Write: 0 START `{dev,0}`; 1 RW_DATA `reg`; 2 RW_DATA `wdata`; 3 STOP.
  - Read: 0 START `{dev,0}`; 1 RW_DATA `reg`; 2 START `{dev,1}`; 3 STOP.
- States:
  - `S_IDLE`: all outputs low; `o_busy`=0. When `i_req`=1, latch the inputs, clear `o_err`, set `step`=0, go to `S_ISSUE`.
  - `S_ISSUE`:
    - Drive the step's strobe high (exactly one strobe high) and `o_addr_cmd_data`.
    - Hold both until `st_tx_in_progress`=1, then drop the strobe and go to `S_WAIT`.
  - `S_WAIT`: strobes low; wait for `st_tx_in_progress`=0, then evaluate:
    - `st_nack_addr`=1: `o_err`=01, go to `S_DONE`. The master is already idle, so no STOP is issued.
    - `st_nack_data`=1: `o_err`=10, go to `S_DONE`.
    - Step 3: go to `S_DONE`.
    - Read step 2: `st_data_ready` must be 1. Capture `i_data` into `o_rd_data`, then go to `S_ISSUE` with `step`=3. If `st_data_ready`=0, wait in `S_WAIT` (counted by the timeout).
    - Otherwise: `step`+1, go to `S_ISSUE`.
  - `S_DONE`: `o_done`=1 for one cycle, `o_busy`=0; go to `S_IDLE`.
- NACK bits are evaluated only in `S_WAIT`. Stale NACK bits left from an earlier failed transaction are cleared by the master on the same edge that raises tx_in_progress, so they are never evaluated.
- Timeout:
  - A per-step counter clears on entry to `S_ISSUE` and increments every cycle in `S_ISSUE`/`S_WAIT`.
  - When it reaches `TIMEOUT`: drop all strobes, `o_err`=11, go to `S_DONE`.
  - The master is not forcibly stopped; the system must reset it.
- `i_req` is ignored while `o_busy`=1.

## Timing
- Reset: state `S_IDLE`, `step`=0, timeout counter 0; all outputs 0; synchroniser flops 0. Reset mid-transaction drops strobes on the next edge; the master must be reset in the same window.
- Accept: `i_req` in cycle N, then `o_busy`=1 and `o_start`=1 in cycle N+1.
- Strobe hold: ≥1 `i2c_clk` period plus 2 `m_clk` cycles of synchroniser latency.
- Strobe deassert: 1 cycle after `st_tx_in_progress` is seen high.
- Status reaction latency: 3 `m_clk` cycles (2 sync + 1 register).
- Completion: `o_done` asserts 1 cycle after the final `S_WAIT` evaluation; `o_busy` falls in the same cycle.
- Back-to-back: a new `i_req` is accepted in the cycle after `o_done` (`S_IDLE`).

## Test plan
- Write dev 0x50, reg 0x10, data 0xA5 with an ACKing slave model:
  - Required bus sequence: START 0xA0, 0x10, 0xA5, STOP.
  - Required completion: `o_done` with `o_err`=00.
  - Each strobe held until tx_in_progress is seen high.
- Read dev 0x50, reg 0x20, slave returns 0x3C:
  - Required bus sequence: 0xA0, 0x20, repeated START 0xA1, NACK+STOP.
  - Required completion: `o_rd_data`=0x3C, `o_err`=00.
- Absent device (address NACK), write dev 0x11:
  - Required: `o_err`=01 after step 0, no STOP strobe issued.
  - Follow-up: a subsequent good write returns `o_err`=00 (stale NACK ignored).
- Data NACK on the register byte: `o_err`=10, `o_done` pulse, then back in `S_IDLE`.
- `TIMEOUT`=16 with `i2c_clk` stopped:
  - Required: `o_start` drops, `o_err`=11, `o_done` at cycle 18 after acceptance.
- `i_req` pulsed while busy is ignored; `reset` asserted during step 2 gives all outputs 0 on the next edge, and a fresh request then completes normally.
